// File: rtl/register_file_32x32_pkg.sv
// Shared constants for the RV32I integer register file.
// Register indices, register count and the default stack-top value.
package register_file_32x32_pkg;

   localparam int NUM_REGS = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd2;

   // Stack top shared with the PC/stack setup at the top level.
   localparam logic [31:0] SP_RESET_DEFAULT = 32'h0000_3FFC;

   // True when an index names a register that actually holds state.
   function automatic logic is_stored(input logic [4:0] idx);
      return idx != REG_ZERO;
   endfunction

endpackage

// File: rtl/decoder2to4.sv
// 2-to-4 one-hot decoder with enable.
// Ports: IN (2b index), EN (enable), OUT (4b one-hot, zero when EN=0).
module decoder2to4 (
   input  logic [1:0] IN,
   input  logic       EN,
   output logic [3:0] OUT
);

   assign OUT = {4{EN}} & (4'b0001 << IN);

endmodule

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable.
// Ports: IN (3b index), EN (enable), OUT (8b one-hot, zero when EN=0).
module decoder3to8 (
   input  logic [2:0] IN,
   input  logic       EN,
   output logic [7:0] OUT
);

   assign OUT = {8{EN}} & (8'b0000_0001 << IN);

endmodule

// File: rtl/decoder5to32.sv
// 5-to-32 one-hot decoder with enable, built from 2-to-4 and 3-to-8.
// Ports: IN (5b index), EN (enable), OUT (32b one-hot, zero when EN=0).
module decoder5to32 (
   input  logic [4:0]  IN,
   input  logic        EN,
   output logic [31:0] OUT
);

   // IN[4:3] picks one of four banks of eight; only that bank is enabled.
   logic [3:0] bank;

   decoder2to4 u_bank (
      .IN  (IN[4:3]),
      .EN  (EN),
      .OUT (bank)
   );

   for (genvar g = 0; g < 4; g++) begin : g_bank
      decoder3to8 u_lo (
         .IN  (IN[2:0]),
         .EN  (bank[g]),
         .OUT (OUT[g*8 +: 8])
      );
   end

endmodule

// File: rtl/register_file_32x32.sv
// RV32I register file: 32 x WIDTH regs, 2 comb read ports, 1 sync write.
// Ports: CLK, RST (async high), WE/WA/WD write, RA1/RA2 -> RD1/RD2 reads.
module register_file_32x32
   import register_file_32x32_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_DEFAULT)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WE,
   input  logic [4:0]       WA,
   input  logic [WIDTH-1:0] WD,
   input  logic [4:0]       RA1,
   input  logic [4:0]       RA2,
   output logic [WIDTH-1:0] RD1,
   output logic [WIDTH-1:0] RD2
);

   logic [NUM_REGS-1:0] strobe;
   logic [WIDTH-1:0]    regs_q [NUM_REGS];
   logic [WIDTH-1:0]    regs_d [NUM_REGS];
   logic                byp1;
   logic                byp2;
   logic [WIDTH-1:0]    rd1;
   logic [WIDTH-1:0]    rd2;

   decoder5to32 u_dec (
      .IN  (WA),
      .EN  (WE),
      .OUT (strobe)
   );

   // x0 slot is pinned to zero so it never holds state.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = strobe[i] ? WD : regs_q[i];
      end
      regs_d[REG_ZERO] = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // strobe[RA] is set exactly when WE=1 and WA==RA, so it doubles as
   // the write-through match.
   assign byp1 = !RST && strobe[RA1];
   assign byp2 = !RST && strobe[RA2];

   always_comb begin
      rd1 = regs_q[RA1];
      if (!is_stored(RA1)) begin
         rd1 = '0;
      end else if (byp1) begin
         rd1 = WD;
      end
   end

   always_comb begin
      rd2 = regs_q[RA2];
      if (!is_stored(RA2)) begin
         rd2 = '0;
      end else if (byp2) begin
         rd2 = WD;
      end
   end

   assign RD1 = rd1;
   assign RD2 = rd2;

endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- RV32I integer register file: 32 x WIDTH-bit registers, two combinational read ports, one synchronous write port.
- Sits directly downstream of decoder5to32. The write address WA goes through decoder5to32, gated by WE on its EN input. The resulting one-hot 32-bit word is the per-register write strobe.
- x0 reads as zero at all times. x2 (sp) resets to a configurable stack-top value.

Parameters:
- WIDTH, 32, data width of each register.
- SP_RESET, 32'h0000_3FFC, reset value of x2 (stack pointer); all other registers reset to 0.

Ports:
- CLK  input  1  clock; all writes occur on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- WE  input  1  write enable; drives decoder5to32 EN.
- WA  input  5  write register index; drives decoder5to32 IN.
- WD  input  WIDTH  write data.
- RA1  input  5  read port 1 register index.
- RA2  input  5  read port 2 register index.
- RD1  output  WIDTH  read port 1 data.
- RD2  output  WIDTH  read port 2 data.

Behaviour:
- Reset:
  - RST high clears x1 and x3..x31 to 0 and sets x2 to SP_RESET, immediately and without waiting for CLK.
  - While RST is high, writes are blocked.
  - During reset, RD1/RD2 show the reset contents: 0 for every index, SP_RESET for index 2.
  - RST asserted mid-operation overrides any write on the same edge.
- Write strobe:
  - strobe[31:0] = decoder5to32(IN=WA, EN=WE).
  - On the CLK rising edge with RST low, each register i with strobe[i]=1 loads WD.
  - At most one strobe bit is ever set. WE=0 gives strobe=0 and no register changes.
- x0:
  - strobe[0] is ignored; x0 is never stored.
  - RD1/RD2 = 0 whenever RA1/RA2 = 0, including on a cycle where WE=1 and WA=0.
- Read:
  - Purely combinational from the array plus bypass; zero latency.
- Write-through bypass:
  - If WE=1, WA!=0 and RA1==WA, then RD1 = WD in the same cycle, before the edge. Same rule for RD2.
  - This lets a writeback in the same cycle as a decode read return the new value without a hazard.
  - The bypass is disabled while RST is high.
- Simultaneous cases:
  - RA1==RA2: both ports return identical data.
  - RA1==RA2==WA!=0 with WE=1: both ports return WD.
- Width rule:
  - WD is stored unmodified; no sign or zero extension.
  - Indices are 5-bit only, so no out-of-range case exists.
- Unknown inputs: X on WA or WE while RST is low leaves register contents undefined. The bench must not drive X there.

Decomposition:
- Shared package constants:
  - REG_ZERO=5'd0, REG_SP=5'd2, NUM_REGS=32.
  - Default SP_RESET value, so the PC/stack setup in the top level uses the same number.
- Sub-module: decoder5to32, instantiated once for the write strobe. It in turn pulls in decoder2to4 and decoder3to8.
- Storage, reset and bypass logic live in register_file_32x32 itself.

Test Plan:
- Reset readback: pulse RST high for 10 time units mid-cycle with no clock edge. Required: RD1 with RA1=2 is 32'h0000_3FFC; RD2 with RA2=5 is 0; RA1=0 gives 0.
- Basic write/read: WE=1, WA=5, WD=32'hDEADBEEF, then one rising edge; WE=0; RA1=5. Required: RD1=32'hDEADBEEF. Every other index (sweep RA2 over 1..31, skipping 5) is unchanged.
- x0 protection: WE=1, WA=0, WD=32'hFFFFFFFF, rising edge; RA1=0. Required: RD1=0 both before and after the edge.
- Bypass: x7 holds 32'h11111111. Set WE=1, WA=7, WD=32'h22222222, RA1=7, RA2=7 and sample before the edge. Required: RD1=RD2=32'h22222222. After the edge, with WE=0, still 32'h22222222.
- WE gating: WE=0, WA=9, WD=32'hA5A5A5A5, rising edge. Required: RD1 with RA1=9 is still 0.
- Reset mid-operation: x3 holds 32'h1234. Assert RST coincident with a write of 32'h5678 to x3. Required: RD1 with RA1=3 is 0 during and after reset, and x2 returns to SP_RESET.
